// File: rtl/oam_dma_controller_if.sv
// Purpose : bundles the CPU-side trigger bus, the DMA read port and the OAM write port of the sprite DMA.
// Latency : wires only; no storage.
// Backpres: none here; the controller halts the CPU through oam_dma.
interface oam_dma_controller_if;
    // CPU write path (trigger) and bus phase
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_we;
    logic        cpu_rw;
    // PPU OAMADDR value captured at trigger time
    logic [7:0]  oam_base;
    // CPU halt request / busy
    logic        oam_dma;
    // DMA read port on the CPU memory bus
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  dma_data_in;
    // OAM write port
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data_in;
    logic        oam_we;

    // DMA controller side
    modport master (
        input  cpu_addr, cpu_data_out, cpu_we, cpu_rw, oam_base, dma_data_in,
        output oam_dma, dma_addr, dma_rd, oam_addr, oam_data_in, oam_we
    );

    // CPU / memory / PPU side
    modport slave (
        output cpu_addr, cpu_data_out, cpu_we, cpu_rw, oam_base, dma_data_in,
        input  oam_dma, dma_addr, dma_rd, oam_addr, oam_data_in, oam_we
    );
endinterface

// File: rtl/oam_dma_controller.sv
// Purpose : sprite DMA; a CPU write to TRIGGER_ADDR copies page $XX00-$XXFF into OAM starting at OAMADDR.
// Latency : busy from the cycle after the trigger; 513 cycles (514 on odd parity) plus one per HALT wait cycle.
// Backpres: waits in HALT while the CPU is still writing (cpu_rw = 0); holds the CPU off via oam_dma while busy.
module oam_dma_controller #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter int          XFER_LEN     = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    oam_dma_controller_if.master   bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    // The byte counter is 8 bits, so the last index is XFER_LEN-1 truncated to 8 bits.
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] base_q,  base_d;
    logic [7:0] idx_q,   idx_d;
    logic       parity_q;

    logic       trigger;
    assign trigger = bus.cpu_we && (bus.cpu_addr == TRIGGER_ADDR);

    // Next-state and transfer bookkeeping; triggers are only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        base_d  = base_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    page_d  = bus.cpu_data_out;
                    base_d  = bus.oam_base;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // The 6502 only honours RDY on read cycles, so wait out its writes.
                if (bus.cpu_rw) begin
                    state_d = parity_q ? S_ALIGN : S_READ;
                end
            end
            S_ALIGN: begin
                state_d = S_READ;
            end
            S_READ: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode straight from the registered state so a reset clears every strobe the following cycle.
    always_comb begin
        bus.oam_dma     = (state_q != S_IDLE);
        bus.dma_rd      = 1'b0;
        bus.dma_addr    = 16'h0000;
        bus.oam_we      = 1'b0;
        bus.oam_addr    = 8'h00;
        bus.oam_data_in = 8'h00;
        if (state_q == S_READ) begin
            bus.dma_rd   = 1'b1;
            bus.dma_addr = {page_q, idx_q};
        end
        if (state_q == S_WRITE) begin
            bus.oam_we      = 1'b1;
            bus.oam_addr    = base_q + idx_q;
            bus.oam_data_in = bus.dma_data_in;
        end
    end

    // State registers; parity free-runs to track the get/put cycle alignment.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            page_q   <= 8'h00;
            base_q   <= 8'h00;
            idx_q    <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            base_q   <= base_d;
            idx_q    <= idx_d;
            parity_q <= ~parity_q;
        end
    end

endmodule
